// File: rtl/alu_mult_seq_if.sv
// Bus between the sequential multiplier, its requester and the shared ALU.
interface alu_mult_seq_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;

  // Requester plus ALU side.
  modport master (
    output start, op_a, op_b, alu_out,
    input  busy, done, hi, lo, alu_ctrl, alu_a, alu_b
  );

  // Multiplier controller side.
  modport slave (
    input  start, op_a, op_b, alu_out,
    output busy, done, hi, lo, alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative 32x32 unsigned multiplier that borrows the shared ALU for 32 shift-add
// steps. The ALU exports no carry, so the carry is recovered from an unsigned compare.
module alu_mult_seq #(
  parameter logic [3:0] ADD_CTRL  = 4'd2,
  parameter logic [3:0] IDLE_CTRL = 4'd0
) (
  input logic          clk,
  input logic          reset,
  alu_mult_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  count_q, count_d;

  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        carry;

  // ALU operand steering: add accumulator and (conditionally) multiplicand while running.
  always_comb begin
    alu_ctrl = IDLE_CTRL;
    alu_a    = '0;
    alu_b    = '0;
    if (state_q == StRun) begin
      alu_ctrl = ADD_CTRL;
      alu_a    = hi_q;
      alu_b    = lo_q[0] ? mcand_q : '0;
    end
  end

  // An unsigned add wrapped iff the sum is below either operand.
  assign carry = (bus.alu_out < alu_a);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (state_q == StDone) state_d = StIdle;
        if (bus.start) begin
          mcand_d = bus.op_a;
          hi_d    = '0;
          lo_d    = bus.op_b;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Right shift of the 65-bit {carry, sum, lo}; the consumed multiplier bit drops out.
        {hi_d, lo_d} = {carry, bus.alu_out, lo_q[31:1]};
        count_d      = count_q + 6'd1;
        if (count_q == 6'd31) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.alu_ctrl = alu_ctrl;
  assign bus.alu_a    = alu_a;
  assign bus.alu_b    = alu_b;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: directed and random multiplies against an arithmetic model.
module tb_alu_mult_seq;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   fails;

  alu_mult_seq_if bus ();

  alu_mult_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in: add for ctrl 2, AND for ctrl 0.
  always_comb begin
    bus.alu_out = '0;
    if (bus.alu_ctrl == 4'd2)      bus.alu_out = bus.alu_a + bus.alu_b;
    else if (bus.alu_ctrl == 4'd0) bus.alu_out = bus.alu_a & bus.alu_b;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Upper word after k steps: the partial product a*(b mod 2^k) shifted down by k.
  function automatic logic [31:0] exp_hi(input logic [31:0] a, input logic [31:0] b,
                                         input int k);
    logic [63:0] pk;
    logic [63:0] mask;
    mask = (64'd1 << k) - 64'd1;
    pk   = {32'd0, a} * ({32'd0, b} & mask);
    return 32'(pk >> k);
  endfunction

  task automatic chk_idle_alu(input string tag);
    chk({tag, "_ctrl"}, 64'(bus.alu_ctrl), 64'd0);
    chk({tag, "_alu_a"}, 64'(bus.alu_a), 64'd0);
    chk({tag, "_alu_b"}, 64'(bus.alu_b), 64'd0);
  endtask

  // One multiply. pre_started: start was already driven in the previous DONE cycle.
  // poke_mid: re-request 7x7 at E5, which must be ignored. chain: hold start in DONE.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit pre_started,
                         input bit poke_mid, input bit chain, input logic [31:0] na,
                         input logic [31:0] nb);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    if (!pre_started) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    for (int k = 0; k < 32; k++) begin
      chk("run_busy", 64'(bus.busy), 64'd1);
      chk("run_done", 64'(bus.done), 64'd0);
      chk("run_ctrl", 64'(bus.alu_ctrl), 64'd2);
      chk("run_alu_a", 64'(bus.alu_a), 64'(exp_hi(a, b, k)));
      chk("run_alu_b", 64'(bus.alu_b), 64'(b[k] ? a : 32'd0));
      if (poke_mid && k == 4) begin
        bus.start = 1'b1;
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd7;
      end
      if (poke_mid && k == 5) bus.start = 1'b0;
      @(negedge clk);
    end
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("done_busy", 64'(bus.busy), 64'd0);
    chk("done_hi", 64'(bus.hi), 64'(p[63:32]));
    chk("done_lo", 64'(bus.lo), 64'(p[31:0]));
    chk_idle_alu("done");
    if (chain) begin
      bus.start = 1'b1;
      bus.op_a  = na;
      bus.op_b  = nb;
    end else begin
      @(negedge clk);
      chk("after_done", 64'(bus.done), 64'd0);
      chk("after_busy", 64'(bus.busy), 64'd0);
      chk("after_hi", 64'(bus.hi), 64'(p[63:32]));
      chk("after_lo", 64'(bus.lo), 64'(p[31:0]));
      chk_idle_alu("after");
    end
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    fails     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;

    #3;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk_idle_alu("rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // 3x5 with an ignored mid-run request, then 7x7 chained from DONE.
    run_mul(32'd3, 32'd5, 1'b0, 1'b1, 1'b1, 32'd7, 32'd7);
    run_mul(32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("lit_lo49", 64'(bus.lo), 64'd49);

    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("lit_ff_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    chk("lit_ff_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
    run_mul(32'h8000_0000, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    run_mul(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Asynchronous reset mid-run, after ten iterations.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = 32'h0000_FFFF;
    bus.op_b  = 32'h0000_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_busy", 64'(bus.busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'd0);
    chk("abort_lo", 64'(bus.lo), 64'd0);
    chk_idle_alu("abort");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("no_done_after_abort", 64'(bus.done), 64'd0);
    end
    run_mul(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      run_mul(ra, rb, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
